// File: rtl/reg_writeback_unit.sv
// Write-back queue feeding the register file write port, with a pending-write scoreboard for decode.
// Optional macro WB_FORWARD_EN adds youngest-pending-value forwarding on read port A.
module reg_writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] D_addr,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    input  logic [ADDR_W-1:0] A_addr,
    input  logic [ADDR_W-1:0] B_addr,
    output logic              A_busy,
    output logic              B_busy,
    output logic              A_fwd_valid,
    output logic [DATA_W-1:0] A_fwd_data,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    logic              take_ld, take_alu, do_push, do_pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              a_hit, b_hit;

    // Ready depends only on occupancy; a same-cycle pop never frees a slot early.
    assign ld_ready  = (count < FULL);
    assign alu_ready = (count < FULL) && !ld_valid;
    assign take_ld   = ld_valid && ld_ready;
    assign take_alu  = alu_valid && alu_ready;
    assign push_addr = take_ld ? ld_addr : alu_addr;
    assign push_data = take_ld ? ld_data : alu_data;
    assign do_push   = (take_ld || take_alu) && (push_addr != '0);
    assign do_pop    = (count != '0);
    assign empty     = (count == '0) && !write_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            write_enable <= 1'b0;
            D_addr       <= '0;
            data_in      <= '0;
        end else begin
            write_enable <= do_pop;
            if (do_pop) begin
                D_addr  <= q_addr[rd_ptr];
                data_in <= q_data[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage is data-only; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_addr[wr_ptr] <= push_addr;
            q_data[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        a_hit = write_enable && (D_addr == A_addr);
        b_hit = write_enable && (D_addr == B_addr);
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_addr[idx] == A_addr) a_hit = 1'b1;
                if (q_addr[idx] == B_addr) b_hit = 1'b1;
            end
        end
    end

    assign A_busy = a_hit && (A_addr != '0);
    assign B_busy = b_hit && (B_addr != '0);

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match (tail-most) wins.
    always_comb begin
        logic [PW-1:0] fidx;
        A_fwd_data = data_in;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (q_addr[fidx] == A_addr))
                A_fwd_data = q_data[fidx];
        end
        if (!A_busy)
            A_fwd_data = '0;
    end
    assign A_fwd_valid = A_busy;
`else
    assign A_fwd_valid = 1'b0;
    assign A_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: a queue-based reference model predicts retired writes.
module tb_reg_writeback_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 0, reset = 1;
    logic              alu_valid = 0, ld_valid = 0;
    logic [ADDR_W-1:0] alu_addr = 0, ld_addr = 0, A_addr = 0, B_addr = 0;
    logic [DATA_W-1:0] alu_data = 0, ld_data = 0;
    logic              alu_ready, ld_ready, write_enable, A_busy, B_busy, A_fwd_valid, empty;
    logic [ADDR_W-1:0] D_addr;
    logic [DATA_W-1:0] data_in, A_fwd_data;

    int checks = 0, errors = 0;

    wr_t pend[$];      // accepted, not yet retired
    wr_t exp_q[$];     // writes the DUT should present on the next sample
    logic ms_we = 0;   // model output stage
    wr_t  ms;

    reg_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .D_addr(D_addr), .data_in(data_in), .write_enable(write_enable),
        .A_addr(A_addr), .B_addr(B_addr), .A_busy(A_busy), .B_busy(B_busy),
        .A_fwd_valid(A_fwd_valid), .A_fwd_data(A_fwd_data), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (ms_we && ms.addr == a) return 1'b1;
        foreach (pend[i]) if (pend[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!m_busy(a)) return v;
        if (ms_we && ms.addr == a) v = ms.data;
        foreach (pend[i]) if (pend[i].addr == a) v = pend[i].data;
        return v;
    endfunction

    // Monitor: every presented write must match the oldest predicted write.
    always @(posedge clk) begin
        #1;
        if (write_enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(D_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(D_addr), 32'(e.addr));
                chk("wr_data", 32'(data_in), 32'(e.data));
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_write", 32'(write_enable), 32'd1);
            exp_q.delete();
        end
    end

    // One clock of stimulus: drive, check combinational outputs, then advance the model.
    task automatic cycle(input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                         input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        logic room, acc;
        wr_t  n;
        @(negedge clk);
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        A_addr = ra; B_addr = rb;
        #1;
        room = pend.size() < DEPTH;
        chk("ld_ready", 32'(ld_ready), 32'(room));
        chk("alu_ready", 32'(alu_ready), 32'(room && !lv));
        chk("A_busy", 32'(A_busy), 32'(m_busy(ra)));
        chk("B_busy", 32'(B_busy), 32'(m_busy(rb)));
        chk("empty", 32'(empty), 32'(pend.size() == 0 && !ms_we));
`ifdef WB_FORWARD_EN
        chk("A_fwd_valid", 32'(A_fwd_valid), 32'(m_busy(ra)));
        chk("A_fwd_data", 32'(A_fwd_data), 32'(m_fwd(ra)));
`else
        chk("A_fwd_valid", 32'(A_fwd_valid), 32'd0);
        chk("A_fwd_data", 32'(A_fwd_data), 32'd0);
`endif
        acc = 0;
        if (lv && room) begin acc = 1; n.addr = la; n.data = ldd; end
        else if (av && room) begin acc = 1; n.addr = aa; n.data = ad; end
        @(posedge clk);
        if (pend.size() > 0) begin
            ms_we = 1;
            ms = pend.pop_front();
            exp_q.push_back(ms);
        end else begin
            ms_we = 0;
        end
        if (acc && n.addr != 0) pend.push_back(n);
    endtask

    task automatic idle(input int n, input logic [ADDR_W-1:0] ra);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_daddr", 32'(D_addr), 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 0;

        // Single load, busy tracking on A
        cycle(1, 3, 16'hBEEF, 0, 0, 0, 3, 3);
        idle(3, 3);
        // Load has priority over ALU; ALU re-presents
        cycle(1, 5, 16'h0022, 1, 4, 16'h0011, 4, 5);
        cycle(0, 0, 0, 1, 4, 16'h0011, 4, 5);
        idle(3, 4);
        // Back-to-back writes r1..r5
        for (int i = 1; i <= 5; i++) cycle(1, ADDR_W'(i), DATA_W'(16'h1000 + i), 0, 0, 0, 3, 5);
        idle(2, 0);
        // Register 0 is never written
        cycle(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        idle(3, 0);
        // Same address twice: last write wins, forwarding picks the youngest
        cycle(1, 2, 16'h0100, 0, 0, 0, 2, 2);
        cycle(1, 2, 16'h0200, 0, 0, 0, 2, 2);
        idle(3, 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, ADDR_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 2) != 0, ADDR_W'($urandom), DATA_W'($urandom),
                  ADDR_W'($urandom), ADDR_W'($urandom));
        idle(3, 0);

        // Asynchronous reset with writes pending
        cycle(1, 6, 16'h0066, 0, 0, 0, 6, 0);
        cycle(1, 7, 16'h0077, 0, 0, 0, 6, 0);
        @(negedge clk);
        ld_valid = 1; ld_addr = 1; ld_data = 16'h0011;
        #1;
        reset = 1;
        #1;
        chk("async_we", 32'(write_enable), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        pend.delete(); exp_q.delete(); ms_we = 0;
        ld_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        idle(4, 7);

        // Post-reset traffic still retires correctly
        for (int i = 0; i < 50; i++)
            cycle($urandom_range(0, 1) != 0, ADDR_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 1) != 0, ADDR_W'($urandom), DATA_W'($urandom),
                  ADDR_W'($urandom), ADDR_W'($urandom));
        idle(3, 0);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
